nasti_rw_scheduler: RTL and testbench
=====================================

// Module: nasti_rw_scheduler
// PURPOSE
//  Core-clock scheduler between nasti_frontend CDC FIFOs (AR, AW, W, B) and the DDR command path.
//  Pops AR/AW heads, arbitrates read-priority with write anti-starvation, and issues one command at a time.
//  Streams write beats from the W FIFO and pushes the write response into the B FIFO.
//  FIFO read ports are first-word-fall-through: head valid while rempty=0; rinc=1 pops it that cycle.
// PARAMETERS
//  C_NASTI_ID_WIDTH    9   transaction ID width
//  C_NASTI_ADDR_WIDTH  32  byte address width
//  C_NASTI_DATA_WIDTH  64  write data width; strobe width = C_NASTI_DATA_WIDTH/8
//  C_STARVE_LIMIT      8   cycles a pending write may lose to reads before it is forced (>=1)
// PORTS
//  core_clk      in   1     single clock
//  core_arstn    in   1     asynchronous active-low reset
//  ar_addr/ar_id/ar_len  in  ADDR/ID/8  AR FIFO head; ar_rempty in 1; ar_rinc out 1
//  aw_addr/aw_id/aw_len  in  ADDR/ID/8  AW FIFO head; aw_rempty in 1; aw_rinc out 1
//  w_data/w_strb/w_last  in  DATA/DATA/8/1  W FIFO head; w_rempty in 1; w_rinc out 1
//  b_id out ID, b_resp out 2, b_wfull in 1, b_winc out 1   B FIFO write port
//  cmd_valid out 1, cmd_ready in 1  command handshake
//  cmd_write out 1, cmd_addr out ADDR, cmd_id out ID, cmd_len out 8  registered command fields
//  wd_valid out 1, wd_ready in 1, wd_data out DATA, wd_strb out DATA/8, wd_last out 1  write beat stream
// BEHAVIOUR
//  Reset: state=IDLE; cmd_* regs, starve_cnt, beat_cnt, b_id, b_resp = 0; all valid/inc outputs 0.
//  States: IDLE, RD_CMD, WR_CMD, WR_DATA, WR_RESP.
//  IDLE: rd_el = !ar_rempty; wr_el = !aw_rempty.
//   grant write if wr_el && (!rd_el || starve_cnt>=C_STARVE_LIMIT); else grant read if rd_el; else stay.
//   On grant: pop head (ar_rinc or aw_rinc =1 that cycle); load cmd_addr/id/len, cmd_write; next RD_CMD/WR_CMD.
//  RD_CMD/WR_CMD: cmd_valid=1, fields stable until cmd_valid&&cmd_ready.
//   RD_CMD handshake -> IDLE. WR_CMD handshake -> WR_DATA, beat_cnt=0, b_id=cmd_id, b_resp=0.
//  WR_DATA: wd_valid = !w_rempty; wd_data/wd_strb = W head (combinational); wd_last = (beat_cnt==cmd_len).
//   w_rinc = wd_valid && wd_ready. Each beat: beat_cnt++; if w_last != wd_last, b_resp <= 2'b10 (sticky).
//   Beat with wd_last=1 accepted -> WR_RESP. Exactly cmd_len+1 beats popped regardless of w_last.
//  WR_RESP: b_winc = !b_wfull; on b_winc -> IDLE. b_wfull holds state indefinitely.
//  starve_cnt: +1 per cycle with !aw_rempty and state in {IDLE,RD_CMD}; saturates at C_STARVE_LIMIT;
//   cleared on write grant.
//  Latency: non-empty FIFO seen in IDLE at cycle N -> cmd_valid=1 at N+1; min 2 cycles per read command.
//  At most one command outstanding; cmd_ready ignored outside RD_CMD/WR_CMD.
//  Simultaneous AR/AW non-empty, starve_cnt<limit -> read wins. cmd_len=255 -> 256 beats; beat_cnt 8 bit, no wrap.
//  Reset mid-burst: immediate return to IDLE; partially consumed W beats not replayed (FIFOs reset in same domain).
//  No pop ever issued when the corresponding rempty=1; no push when b_wfull=1.
// TESTING
//  1 Single AR addr=0x100 id=3 len=0, cmd_ready=1 -> cmd_valid one cycle later, write=0, ar_rinc one pulse.
//  2 AW id=5 len=3 + 4 W beats (w_last on 4th), wd_ready=1 -> 4 w_rinc, wd_last on beat 4, B push id=5 resp=0.
//  3 AR and AW heads held non-empty continuously, LIMIT=8 -> reads win until starve_cnt=8, then one write granted.
//  4 len=1 with w_last=1 on beat 1 -> 2 beats popped, b_resp=2'b10.
//  5 b_wfull=1 for 20 cycles after burst -> stays in WR_RESP, b_winc=0, no new commands; push on release.
//  6 Assert core_arstn low in WR_DATA beat 2 -> all outputs 0 asynchronously; after release, fresh AR served normally.

Source files
------------

// File: rtl/nasti_rw_scheduler.sv
// nasti_rw_scheduler
//   Core-clock scheduler between the NASTI frontend CDC FIFOs (AR, AW, W, B)
//   and the DDR command path. It pops AR/AW heads and arbitrates them with
//   read priority, bounded by a write anti-starvation counter. It issues one
//   command at a time, streams the write beats from the W FIFO, and pushes
//   the write response into the B FIFO.
//
// Ports
//   core_clk, core_arstn       clock, asynchronous active-low reset
//   ar_* / aw_*                FWFT FIFO heads (addr, id, len, rempty) and pop (rinc)
//   w_data/w_strb/w_last       W FIFO head; w_rempty in, w_rinc out
//   b_id/b_resp/b_winc         B FIFO write port; b_wfull in
//   cmd_valid/cmd_ready        command handshake; cmd_write/addr/id/len registered fields
//   wd_valid/wd_ready          write beat handshake; wd_data/strb/last beat payload
//   dbg_state                  current FSM state (IDLE=0 RD_CMD=1 WR_CMD=2 WR_DATA=3 WR_RESP=4)
//
// Handshakes: a transfer happens on a rising clock edge where valid and ready
// are both 1. The valid side holds its payload stable until then. FIFO
// read ports are first-word-fall-through: a head is valid while rempty=0,
// and rinc=1 pops it on that edge.
module nasti_rw_scheduler #(
    parameter int C_NASTI_ID_WIDTH   = 9,
    parameter int C_NASTI_ADDR_WIDTH = 32,
    parameter int C_NASTI_DATA_WIDTH = 64,
    parameter int C_STARVE_LIMIT     = 8
) (
    input  logic                            core_clk,
    input  logic                            core_arstn,
    input  logic [C_NASTI_ADDR_WIDTH-1:0]   ar_addr,
    input  logic [C_NASTI_ID_WIDTH-1:0]     ar_id,
    input  logic [7:0]                      ar_len,
    input  logic                            ar_rempty,
    output logic                            ar_rinc,
    input  logic [C_NASTI_ADDR_WIDTH-1:0]   aw_addr,
    input  logic [C_NASTI_ID_WIDTH-1:0]     aw_id,
    input  logic [7:0]                      aw_len,
    input  logic                            aw_rempty,
    output logic                            aw_rinc,
    input  logic [C_NASTI_DATA_WIDTH-1:0]   w_data,
    input  logic [C_NASTI_DATA_WIDTH/8-1:0] w_strb,
    input  logic                            w_last,
    input  logic                            w_rempty,
    output logic                            w_rinc,
    output logic [C_NASTI_ID_WIDTH-1:0]     b_id,
    output logic [1:0]                      b_resp,
    input  logic                            b_wfull,
    output logic                            b_winc,
    output logic                            cmd_valid,
    input  logic                            cmd_ready,
    output logic                            cmd_write,
    output logic [C_NASTI_ADDR_WIDTH-1:0]   cmd_addr,
    output logic [C_NASTI_ID_WIDTH-1:0]     cmd_id,
    output logic [7:0]                      cmd_len,
    output logic                            wd_valid,
    input  logic                            wd_ready,
    output logic [C_NASTI_DATA_WIDTH-1:0]   wd_data,
    output logic [C_NASTI_DATA_WIDTH/8-1:0] wd_strb,
    output logic                            wd_last,
    output logic [2:0]                      dbg_state
);

    localparam int SW = $clog2(C_STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(C_STARVE_LIMIT);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_CMD  = 3'd1,
        WR_CMD  = 3'd2,
        WR_DATA = 3'd3,
        WR_RESP = 3'd4
    } state_t;

    state_t                        state_q, state_d;
    logic                          cmd_write_q, cmd_write_d;
    logic [C_NASTI_ADDR_WIDTH-1:0] cmd_addr_q, cmd_addr_d;
    logic [C_NASTI_ID_WIDTH-1:0]   cmd_id_q, cmd_id_d;
    logic [7:0]                    cmd_len_q, cmd_len_d;
    logic [SW-1:0]                 starve_cnt_q, starve_cnt_d;
    logic [7:0]                    beat_cnt_q, beat_cnt_d;
    logic [C_NASTI_ID_WIDTH-1:0]   b_id_q, b_id_d;
    logic [1:0]                    b_resp_q, b_resp_d;

    always_ff @(posedge core_clk or negedge core_arstn) begin
        if (!core_arstn) begin
            state_q      <= IDLE;
            cmd_write_q  <= 1'b0;
            cmd_addr_q   <= '0;
            cmd_id_q     <= '0;
            cmd_len_q    <= '0;
            starve_cnt_q <= '0;
            beat_cnt_q   <= '0;
            b_id_q       <= '0;
            b_resp_q     <= '0;
        end else begin
            state_q      <= state_d;
            cmd_write_q  <= cmd_write_d;
            cmd_addr_q   <= cmd_addr_d;
            cmd_id_q     <= cmd_id_d;
            cmd_len_q    <= cmd_len_d;
            starve_cnt_q <= starve_cnt_d;
            beat_cnt_q   <= beat_cnt_d;
            b_id_q       <= b_id_d;
            b_resp_q     <= b_resp_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cmd_write_d  = cmd_write_q;
        cmd_addr_d   = cmd_addr_q;
        cmd_id_d     = cmd_id_q;
        cmd_len_d    = cmd_len_q;
        starve_cnt_d = starve_cnt_q;
        beat_cnt_d   = beat_cnt_q;
        b_id_d       = b_id_q;
        b_resp_d     = b_resp_q;
        ar_rinc      = 1'b0;
        aw_rinc      = 1'b0;
        w_rinc       = 1'b0;
        b_winc       = 1'b0;
        cmd_valid    = 1'b0;
        wd_valid     = 1'b0;
        wd_data      = '0;
        wd_strb      = '0;
        wd_last      = 1'b0;

        // A pending write ages while reads hold the command path. A write
        // grant below overrides this increment with a clear.
        if (!aw_rempty && (state_q == IDLE || state_q == RD_CMD) &&
            starve_cnt_q < STARVE_MAX) begin
            starve_cnt_d = starve_cnt_q + SW'(1);
        end

        case (state_q)
            IDLE: begin
                if (!aw_rempty && (ar_rempty || starve_cnt_q >= STARVE_MAX)) begin
                    aw_rinc      = 1'b1;
                    cmd_write_d  = 1'b1;
                    cmd_addr_d   = aw_addr;
                    cmd_id_d     = aw_id;
                    cmd_len_d    = aw_len;
                    starve_cnt_d = '0;
                    state_d      = WR_CMD;
                end else if (!ar_rempty) begin
                    ar_rinc     = 1'b1;
                    cmd_write_d = 1'b0;
                    cmd_addr_d  = ar_addr;
                    cmd_id_d    = ar_id;
                    cmd_len_d   = ar_len;
                    state_d     = RD_CMD;
                end
            end
            RD_CMD: begin
                cmd_valid = 1'b1;
                if (cmd_ready) state_d = IDLE;
            end
            WR_CMD: begin
                cmd_valid = 1'b1;
                if (cmd_ready) begin
                    state_d    = WR_DATA;
                    beat_cnt_d = '0;
                    b_id_d     = cmd_id_q;
                    b_resp_d   = 2'b00;
                end
            end
            WR_DATA: begin
                wd_valid = !w_rempty;
                wd_data  = w_data;
                wd_strb  = w_strb;
                // Burst length comes from AW; w_last from the master is only
                // checked against it, so a bad w_last never changes the count.
                wd_last  = (beat_cnt_q == cmd_len_q);
                w_rinc   = wd_valid && wd_ready;
                if (w_rinc) begin
                    if (w_last != wd_last) b_resp_d = 2'b10;
                    if (wd_last) state_d = WR_RESP;
                    else beat_cnt_d = beat_cnt_q + 8'd1;
                end
            end
            WR_RESP: begin
                b_winc = !b_wfull;
                if (b_winc) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign cmd_write = cmd_write_q;
    assign cmd_addr  = cmd_addr_q;
    assign cmd_id    = cmd_id_q;
    assign cmd_len   = cmd_len_q;
    assign b_id      = b_id_q;
    assign b_resp    = b_resp_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_nasti_rw_scheduler.sv
module tb_nasti_rw_scheduler;

    localparam int AW = 32;
    localparam int IW = 9;
    localparam int DW = 64;
    localparam int SBW = DW / 8;
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WR_DATA = 3'd3;
    localparam logic [2:0] S_WR_RESP = 3'd4;

    logic          core_clk;
    logic          core_arstn;
    logic [AW-1:0] ar_addr, aw_addr, cmd_addr;
    logic [IW-1:0] ar_id, aw_id, cmd_id, b_id;
    logic [7:0]    ar_len, aw_len, cmd_len;
    logic          ar_rempty, aw_rempty, w_rempty;
    logic          ar_rinc, aw_rinc, w_rinc;
    logic [DW-1:0] w_data, wd_data;
    logic [SBW-1:0] w_strb, wd_strb;
    logic          w_last, wd_last;
    logic [1:0]    b_resp;
    logic          b_wfull, b_winc;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic          wd_valid, wd_ready;
    logic [2:0]    dbg_state;

    nasti_rw_scheduler #(
        .C_NASTI_ID_WIDTH(IW), .C_NASTI_ADDR_WIDTH(AW),
        .C_NASTI_DATA_WIDTH(DW), .C_STARVE_LIMIT(8)
    ) dut (
        .core_clk(core_clk), .core_arstn(core_arstn),
        .ar_addr(ar_addr), .ar_id(ar_id), .ar_len(ar_len), .ar_rempty(ar_rempty), .ar_rinc(ar_rinc),
        .aw_addr(aw_addr), .aw_id(aw_id), .aw_len(aw_len), .aw_rempty(aw_rempty), .aw_rinc(aw_rinc),
        .w_data(w_data), .w_strb(w_strb), .w_last(w_last), .w_rempty(w_rempty), .w_rinc(w_rinc),
        .b_id(b_id), .b_resp(b_resp), .b_wfull(b_wfull), .b_winc(b_winc),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_id(cmd_id), .cmd_len(cmd_len),
        .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
        .wd_strb(wd_strb), .wd_last(wd_last), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial core_clk = 1'b0;
    always #5 core_clk = ~core_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- source FIFO models and scoreboard ----------------
    logic [AW+IW+7:0]  ar_fifo[$];
    logic [AW+IW+7:0]  aw_fifo[$];
    logic [DW+SBW:0]   w_fifo[$];
    logic [AW+IW+8:0]  exp_cmd_q[$];
    logic [DW+SBW:0]   exp_beat_q[$];
    logic [IW+1:0]     exp_b_q[$];

    int checks = 0;
    int errors = 0;
    int ar_pops = 0;
    int aw_pops = 0;
    int w_pops = 0;
    logic rand_mode = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic refresh();
        if (ar_fifo.size() > 0) begin
            {ar_addr, ar_id, ar_len} = ar_fifo[0];
            ar_rempty = 1'b0;
        end else begin
            {ar_addr, ar_id, ar_len} = '0;
            ar_rempty = 1'b1;
        end
        if (aw_fifo.size() > 0) begin
            {aw_addr, aw_id, aw_len} = aw_fifo[0];
            aw_rempty = 1'b0;
        end else begin
            {aw_addr, aw_id, aw_len} = '0;
            aw_rempty = 1'b1;
        end
        if (w_fifo.size() > 0) begin
            {w_data, w_strb, w_last} = w_fifo[0];
            w_rempty = 1'b0;
        end else begin
            {w_data, w_strb, w_last} = '0;
            w_rempty = 1'b1;
        end
    endtask

    // FIFO pops happen on the edge where the DUT asserts rinc; heads move 1ns later.
    always @(posedge core_clk) begin
        if (ar_rinc && ar_fifo.size() > 0) begin void'(ar_fifo.pop_front()); ar_pops++; end
        if (aw_rinc && aw_fifo.size() > 0) begin void'(aw_fifo.pop_front()); aw_pops++; end
        if (w_rinc && w_fifo.size() > 0) begin void'(w_fifo.pop_front()); w_pops++; end
        #1 refresh();
    end

    // Output monitor: handshakes are sampled mid-cycle, ahead of the edge that completes them.
    always @(negedge core_clk) begin
        if (cmd_valid && cmd_ready) begin
            if (exp_cmd_q.size() == 0) check("cmd_unexpected", 1, 0);
            else check("cmd", {cmd_write, cmd_addr, cmd_id, cmd_len}, exp_cmd_q.pop_front());
        end
        if (wd_valid && wd_ready) begin
            if (exp_beat_q.size() == 0) check("beat_unexpected", 1, 0);
            else check("beat", {wd_data, wd_strb, wd_last}, exp_beat_q.pop_front());
        end
        if (b_winc) begin
            if (exp_b_q.size() == 0) check("bresp_unexpected", 1, 0);
            else check("bresp", {b_id, b_resp}, exp_b_q.pop_front());
        end
        if ((ar_rinc && ar_rempty) || (aw_rinc && aw_rempty) || (w_rinc && w_rempty))
            check("pop_when_empty", 1, 0);
        if (b_winc && b_wfull) check("push_when_full", 1, 0);
    end

    // ---------------- driver tasks ----------------
    task automatic push_ar(input logic [AW-1:0] a, input logic [IW-1:0] id, input logic [7:0] len);
        ar_fifo.push_back({a, id, len});
        exp_cmd_q.push_back({1'b0, a, id, len});
        refresh();
    endtask

    task automatic push_aw(input logic [AW-1:0] a, input logic [IW-1:0] id, input logic [7:0] len);
        aw_fifo.push_back({a, id, len});
        exp_cmd_q.push_back({1'b1, a, id, len});
        refresh();
    endtask

    task automatic push_w(input logic master_last, input logic exp_last);
        logic [DW-1:0] d;
        logic [SBW-1:0] s;
        d = {$urandom, $urandom};
        s = SBW'($urandom_range(0, 255));
        w_fifo.push_back({d, s, master_last});
        exp_beat_q.push_back({d, s, exp_last});
        refresh();
    endtask

    task automatic step();
        @(posedge core_clk);
        #2;
        if (rand_mode) begin
            cmd_ready = 1'($urandom_range(0, 1));
            wd_ready  = 1'($urandom_range(0, 1));
        end
    endtask

    function automatic bit busy();
        return exp_cmd_q.size() != 0 || exp_beat_q.size() != 0 || exp_b_q.size() != 0 ||
               ar_fifo.size() != 0 || aw_fifo.size() != 0 || w_fifo.size() != 0 ||
               dbg_state != S_IDLE;
    endfunction

    task automatic wait_done(input string name, input int budget);
        int n;
        n = 0;
        while (busy() && n < budget) begin
            step();
            n++;
        end
        check({name, "_done"}, 128'(n < budget), 1);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_ctl"}, {cmd_valid, wd_valid, w_rinc, ar_rinc, aw_rinc, b_winc, wd_last}, 0);
        check({name, "_cmd"}, {cmd_write, cmd_addr, cmd_id, cmd_len}, 0);
        check({name, "_b"}, {b_id, b_resp}, 0);
        check({name, "_wd"}, {wd_data, wd_strb}, 0);
        check({name, "_state"}, dbg_state, S_IDLE);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [IW-1:0] id;
        logic [7:0]    len;
        int            last_at;   // beat index carrying master w_last (-1: none)
        logic [1:0]    exp_resp;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int base;
        int n;

        vecs[0] = '{1'b0, 32'h0000_2000, 9'h1FF, 8'd0,   0,   2'b00};
        vecs[1] = '{1'b0, 32'hFFFF_FFC0, 9'h000, 8'd255, 0,   2'b00};
        vecs[2] = '{1'b1, 32'h0000_3000, 9'h0AA, 8'd0,   0,   2'b00};
        vecs[3] = '{1'b1, 32'h0000_4000, 9'h101, 8'd1,   0,   2'b10};
        vecs[4] = '{1'b1, 32'h0000_5000, 9'h002, 8'd7,   7,   2'b00};
        vecs[5] = '{1'b1, 32'h0000_6000, 9'h1FE, 8'd2,   -1,  2'b10};
        vecs[6] = '{1'b1, 32'h0000_7000, 9'h033, 8'd255, 255, 2'b00};

        core_arstn = 1'b0;
        cmd_ready  = 1'b0;
        wd_ready   = 1'b0;
        b_wfull    = 1'b0;
        refresh();
        repeat (3) @(posedge core_clk);
        #2;
        check_reset_outputs("reset");
        core_arstn = 1'b1;
        cmd_ready  = 1'b1;
        wd_ready   = 1'b1;
        step();

        // Single read: pop in the same cycle, command valid on the next one.
        base = ar_pops;
        push_ar(32'h100, 9'd3, 8'd0);
        @(negedge core_clk);
        check("t1_pop_cycle", {ar_rinc, cmd_valid}, 2'b10);
        @(negedge core_clk);
        check("t1_cmd_cycle", {cmd_valid, cmd_write, ar_rinc}, 3'b100);
        wait_done("t1", 50);
        check("t1_ar_pops", ar_pops - base, 1);

        // Four-beat write with a correct w_last.
        base = w_pops;
        push_aw(32'h200, 9'd5, 8'd3);
        for (int i = 0; i < 4; i++) push_w(i == 3, i == 3);
        exp_b_q.push_back({9'd5, 2'b00});
        wait_done("t2", 100);
        check("t2_w_pops", w_pops - base, 4);

        // Table rows, with random back-pressure on cmd_ready / wd_ready.
        rand_mode = 1'b1;
        for (int v = 0; v < 7; v++) begin
            if (vecs[v].wr) begin
                base = w_pops;
                push_aw(vecs[v].addr, vecs[v].id, vecs[v].len);
                for (int b = 0; b <= int'(vecs[v].len); b++)
                    push_w(b == vecs[v].last_at, b == int'(vecs[v].len));
                exp_b_q.push_back({vecs[v].id, vecs[v].exp_resp});
                wait_done($sformatf("vec%0d", v), 3000);
                check($sformatf("vec%0d_w_pops", v), w_pops - base, int'(vecs[v].len) + 1);
            end else begin
                base = ar_pops;
                push_ar(vecs[v].addr, vecs[v].id, vecs[v].len);
                wait_done($sformatf("vec%0d", v), 200);
                check($sformatf("vec%0d_ar_pops", v), ar_pops - base, 1);
            end
        end
        rand_mode = 1'b0;
        cmd_ready = 1'b1;
        wd_ready  = 1'b1;
        step();

        // Starvation: with both heads always present, four reads take the
        // counter to 8 (two cycles each), then the write is forced through.
        for (int i = 0; i < 8; i++)
            ar_fifo.push_back({32'h1000 + 32'(i * 64), 9'(i), 8'(i)});
        aw_fifo.push_back({32'hC000, 9'h0C5, 8'd0});
        for (int i = 0; i < 4; i++) exp_cmd_q.push_back({1'b0, 32'h1000 + 32'(i * 64), 9'(i), 8'(i)});
        exp_cmd_q.push_back({1'b1, 32'hC000, 9'h0C5, 8'd0});
        for (int i = 4; i < 8; i++) exp_cmd_q.push_back({1'b0, 32'h1000 + 32'(i * 64), 9'(i), 8'(i)});
        push_w(1'b1, 1'b1);
        exp_b_q.push_back({9'h0C5, 2'b00});
        wait_done("t3", 200);

        // B FIFO full: the scheduler parks in WR_RESP and starts nothing new.
        b_wfull = 1'b1;
        push_aw(32'h8000, 9'h044, 8'd0);
        push_w(1'b1, 1'b1);
        exp_b_q.push_back({9'h044, 2'b00});
        n = 0;
        while (dbg_state != S_WR_RESP && n < 50) begin
            step();
            n++;
        end
        check("t5_reach_resp", 128'(n < 50), 1);
        push_ar(32'h9000, 9'h055, 8'd2);
        for (int i = 0; i < 20; i++) begin
            step();
            @(negedge core_clk);
            check($sformatf("t5_hold%0d", i), {b_winc, cmd_valid, ar_rinc, dbg_state}, {3'b000, S_WR_RESP});
        end
        step();
        b_wfull = 1'b0;
        wait_done("t5", 50);

        // Asynchronous reset in the middle of a write burst.
        base = w_pops;
        push_aw(32'hA000, 9'd7, 8'd3);
        for (int i = 0; i < 4; i++) push_w(i == 3, i == 3);
        exp_b_q.push_back({9'd7, 2'b00});
        n = 0;
        while (w_pops < base + 1 && n < 50) begin
            step();
            n++;
        end
        check("t6_first_beat", 128'(n < 50), 1);
        check("t6_in_data", dbg_state, S_WR_DATA);
        #1;
        core_arstn = 1'b0;
        #1;
        check_reset_outputs("t6_reset");
        ar_fifo.delete();
        aw_fifo.delete();
        w_fifo.delete();
        exp_cmd_q.delete();
        exp_beat_q.delete();
        exp_b_q.delete();
        refresh();
        repeat (2) step();
        core_arstn = 1'b1;
        step();
        push_ar(32'hB000, 9'h012, 8'd4);
        wait_done("t6_after", 50);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
